// File: rtl/seg_scan_ctrl_if.sv
// Update port for seg_scan_ctrl: the producer offers a new BCD value plus
// decimal points, and the controller accepts it into its shadow register.
interface seg_scan_ctrl_if #(
  parameter int unsigned NDIG = 8
) ();
  logic                valid;
  logic                ready;
  logic [4*NDIG-1:0]   data;
  logic [NDIG-1:0]     dp;

  modport master (output valid, output data, output dp, input ready);
  modport slave  (input valid, input data, input dp, output ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller. Scans NDIG digits through one shared
// external decoder, with a blank gap after each digit. New values land in a
// shadow register and are only copied to the displayed value at frame wrap.
// Optional leading-zero blanking: define SEG_SCAN_LZ_BLANK_EN.
module seg_scan_ctrl #(
  parameter int unsigned NDIG = 8,
  parameter int unsigned DIV  = 1000,
  parameter int unsigned GAP  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_scan_ctrl_if.slave    upd,
  output logic [3:0]        dec_b,
  input  logic [6:0]        dec_h,
  output logic [6:0]        seg,
  output logic              dp_n,
  output logic [NDIG-1:0]   an_n,
  output logic              frame_done
);

  localparam int unsigned CntMax = (DIV > GAP) ? DIV : GAP;
  localparam int unsigned CW     = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned IW     = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [CW-1:0] DivLast = CW'(DIV - 1);
  localparam logic [CW-1:0] GapLast = CW'(GAP - 1);
  localparam logic [IW-1:0] IdxLast = IW'(NDIG - 1);

  typedef enum logic {StShow, StGap} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  // The GAP right after reset must not advance idx, so digit 0 is lit first.
  logic              first_q, first_d;
  logic              wrap;

  logic [4*NDIG-1:0] active_data, shadow_data;
  logic [NDIG-1:0]   active_dp, shadow_dp;
  logic              pending;
  logic              xfer;

  logic [3:0]        nib;
  logic              dp_sel;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StGap;
      cnt_q   <= '0;
      idx_q   <= '0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      first_q <= first_d;
    end
  end

  // FSM next state: SHOW for DIV clocks, GAP for GAP clocks, idx advances at end of GAP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    first_d = first_q;
    wrap    = 1'b0;
    unique case (state_q)
      StShow: begin
        if (cnt_q == DivLast) begin
          state_d = StGap;
          cnt_d   = '0;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          state_d = StShow;
          cnt_d   = '0;
          first_d = 1'b0;
          if (!first_q) begin
            if (idx_q == IdxLast) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
        end
      end
      default: begin
        state_d = StGap;
        cnt_d   = '0;
      end
    endcase
  end

  assign frame_done = wrap;
  assign upd.ready  = !pending;
  assign xfer       = upd.valid && !pending;

  // Shadow load on handshake; shadow -> active only at frame wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_data <= '0;
      active_dp   <= '0;
      shadow_data <= '0;
      shadow_dp   <= '0;
      pending     <= 1'b0;
    end else if (wrap && pending) begin
      active_data <= shadow_data;
      active_dp   <= shadow_dp;
      pending     <= 1'b0;
    end else if (xfer) begin
      shadow_data <= upd.data;
      shadow_dp   <= upd.dp;
      pending     <= 1'b1;
    end
  end

  // Select the nibble and decimal point of the current digit
  always_comb begin
    nib    = 4'd0;
    dp_sel = 1'b0;
    for (int j = 0; j < NDIG; j++) begin
      if (idx_q == IW'(j)) begin
        nib    = active_data[j*4 +: 4];
        dp_sel = active_dp[j];
      end
    end
  end

`ifdef SEG_SCAN_LZ_BLANK_EN
  logic lz_zero;

  // Digit is a leading zero when it and every more significant digit are 0
  always_comb begin
    lz_zero = 1'b1;
    for (int j = 0; j < NDIG; j++) begin
      if (IW'(j) >= idx_q && active_data[j*4 +: 4] != 4'd0) begin
        lz_zero = 1'b0;
      end
    end
  end

  // 4'hF decodes to blank; digit 0 is always shown
  assign dec_b = (state_q == StShow && lz_zero && idx_q != '0) ? 4'hF : nib;
`else
  assign dec_b = nib;
`endif

  // Registered pin drivers, one cycle behind the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg  <= 7'h7F;
      an_n <= '1;
      dp_n <= 1'b1;
    end else if (state_q == StShow) begin
      seg  <= dec_h;
      an_n <= ~(NDIG'(1) << idx_q);
      dp_n <= ~dp_sel;
    end else begin
      seg  <= 7'h7F;
      an_n <= '1;
      dp_n <= 1'b1;
    end
  end

endmodule
